regfile_sb: RTL and testbench

//  Parametrised multi-read register file with an integrated scoreboard, replacing the fixed
//  16x24 regfile. It sits between the decoder (issue/read) and the writeback stage.
//  It tracks registers with a pending write, flags read-after-write and write-after-write

---
 rtl/regfile_sb.sv | 113 +++++++++++
 tb/tb_regfile_sb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read register file with pending-write scoreboard.
// Optional same-cycle writeback bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int                     WIDTH    = 24,
   parameter int                     DEPTH    = 16,
   parameter int                     AW       = $clog2(DEPTH),
   parameter bit                     ZERO_REG = 1'b0,
   parameter logic [DEPTH*WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    dst,
   input  logic [WIDTH-1:0] data,
   input  logic [AW-1:0]    src0,
   input  logic [AW-1:0]    src1,
   output logic [WIDTH-1:0] outa,
   output logic [WIDTH-1:0] outb,
   input  logic             iss_vld,
   input  logic [AW-1:0]    iss_dst,
   output logic             stall,
   output logic             busy0,
   output logic             busy1,
   input  logic             sb_clr,
   output logic [AW:0]      pend_cnt,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0] pend_q, pend_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] dbg_q;

   logic live_dst, live_s0, live_s1, live_iss, live_dbg;
   logic wr_ok, acc, waw;
   logic hit0, hit1, hitd;
   logic [WIDTH-1:0] rd0, rd1, rdd;

   // address 0 is hardwired when ZERO_REG is set
   assign live_dst = !(ZERO_REG && dst     == '0);
   assign live_s0  = !(ZERO_REG && src0    == '0);
   assign live_s1  = !(ZERO_REG && src1    == '0);
   assign live_iss = !(ZERO_REG && iss_dst == '0);
   assign live_dbg = !(ZERO_REG && dbg_sel == '0);

   assign wr_ok = we & live_dst;

   assign rd0 = live_s0  ? regs_q[src0]    : '0;
   assign rd1 = live_s1  ? regs_q[src1]    : '0;
   assign rdd = live_dbg ? regs_q[dbg_sel] : '0;

`ifdef REGFILE_BYPASS_EN
   assign hit0 = wr_ok & (dst == src0);
   assign hit1 = wr_ok & (dst == src1);
   assign hitd = we & (dst == iss_dst);
`else
   assign hit0 = 1'b0;
   assign hit1 = 1'b0;
   assign hitd = 1'b0;
`endif

   assign outa = hit0 ? data : rd0;
   assign outb = hit1 ? data : rd1;

   assign busy0 = live_s0 & pend_q[src0] & ~hit0;
   assign busy1 = live_s1 & pend_q[src1] & ~hit1;
   assign waw   = pend_q[iss_dst] & ~hitd;
   assign stall = iss_vld & (busy0 | busy1 | waw);
   assign acc   = iss_vld & ~stall & live_iss;

   // next pending set: writeback clears, issue sets (issue wins), flush clears all
   always_comb begin
      pend_d = pend_q;
      if (wr_ok) pend_d[dst] = 1'b0;
      if (acc) pend_d[iss_dst] = 1'b1;
      if (sb_clr) pend_d = '0;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
   end

   // register storage, loaded from the reset image
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= (ZERO_REG && i == 0) ? '0 : RST_VAL[i*WIDTH +: WIDTH];
      end else if (wr_ok) begin
         regs_q[dst] <= data;
      end
   end

   // scoreboard bits and their registered population count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   // debug port samples the pre-write contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dbg_q <= '0;
      else        dbg_q <= rdd;
   end

   assign pend_cnt = cnt_q;
   assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed + random checks of regfile_sb against a model.
// Two instances: ZERO_REG=0 (index 0) and ZERO_REG=1 (index 1).
module tb_regfile_sb;

   function automatic logic [383:0] mk_rv();
      logic [383:0] r;
      for (int i = 0; i < 16; i++)
         r[i*24 +: 24] = (24'(i) * 24'h010101) ^ 24'h5A0000;
      r[23:0]  = 24'h800320;
      r[47:24] = 24'h430002;
      return r;
   endfunction

   localparam logic [383:0] RV = mk_rv();
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, iss_vld, sb_clr;
   logic [3:0]  dst, src0, src1, iss_dst, dbg_sel;
   logic [23:0] data;

   logic [23:0] outa [2];
   logic [23:0] outb [2];
   logic [23:0] dbg_data [2];
   logic        stall [2];
   logic        busy0 [2];
   logic        busy1 [2];
   logic [4:0]  pend_cnt [2];

   logic [23:0] mreg  [2][16];
   bit          mpend [2][16];
   int          mcnt  [2];
   logic [23:0] mdbg  [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_sb #(.ZERO_REG(1'b0), .RST_VAL(RV)) u_dut (
      .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data),
      .src0(src0), .src1(src1), .outa(outa[0]), .outb(outb[0]),
      .iss_vld(iss_vld), .iss_dst(iss_dst), .stall(stall[0]),
      .busy0(busy0[0]), .busy1(busy1[0]), .sb_clr(sb_clr),
      .pend_cnt(pend_cnt[0]), .dbg_sel(dbg_sel), .dbg_data(dbg_data[0])
   );

   regfile_sb #(.ZERO_REG(1'b1), .RST_VAL(RV)) u_dutz (
      .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data),
      .src0(src0), .src1(src1), .outa(outa[1]), .outb(outb[1]),
      .iss_vld(iss_vld), .iss_dst(iss_dst), .stall(stall[1]),
      .busy0(busy0[1]), .busy1(busy1[1]), .sb_clr(sb_clr),
      .pend_cnt(pend_cnt[1]), .dbg_sel(dbg_sel), .dbg_data(dbg_data[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] rv_slice(int z, int a);
      if (z == 1 && a == 0) return 24'h0;
      return RV[a*24 +: 24];
   endfunction

   function automatic logic [23:0] m_rd(int z, logic [3:0] a);
      if (z == 1 && a == 0) return 24'h0;
      return mreg[z][a];
   endfunction

   function automatic bit m_hit(int z, logic [3:0] a);
      return BYP && we && dst == a && !(z == 1 && dst == 0);
   endfunction

   function automatic logic [23:0] m_out(int z, logic [3:0] a);
      return m_hit(z, a) ? data : m_rd(z, a);
   endfunction

   function automatic bit m_busy(int z, logic [3:0] a);
      if (z == 1 && a == 0) return 1'b0;
      return mpend[z][a] && !m_hit(z, a);
   endfunction

   function automatic bit m_stall(int z);
      bit waw;
      waw = mpend[z][iss_dst] && !(BYP && we && dst == iss_dst);
      return iss_vld && (m_busy(z, src0) || m_busy(z, src1) || waw);
   endfunction

   task automatic m_reset();
      for (int z = 0; z < 2; z++) begin
         for (int a = 0; a < 16; a++) begin
            mreg[z][a]  = rv_slice(z, a);
            mpend[z][a] = 1'b0;
         end
         mcnt[z] = 0;
         mdbg[z] = 24'h0;
      end
   endtask

   // one clock: check combinational outputs, advance model, check registered
   task automatic cyc();
      bit          acc  [2];
      bit          wrok [2];
      logic [23:0] dn   [2];
      #2;
      for (int z = 0; z < 2; z++) begin
         chk($sformatf("outa%0d", z), 32'(outa[z]), 32'(m_out(z, src0)));
         chk($sformatf("outb%0d", z), 32'(outb[z]), 32'(m_out(z, src1)));
         chk($sformatf("busy0_%0d", z), 32'(busy0[z]), 32'(m_busy(z, src0)));
         chk($sformatf("busy1_%0d", z), 32'(busy1[z]), 32'(m_busy(z, src1)));
         chk($sformatf("stall%0d", z), 32'(stall[z]), 32'(m_stall(z)));
         acc[z]  = iss_vld && !m_stall(z) && !(z == 1 && iss_dst == 0);
         wrok[z] = we && !(z == 1 && dst == 0);
         dn[z]   = m_rd(z, dbg_sel);
      end
      @(posedge clk);
      #1;
      for (int z = 0; z < 2; z++) begin
         if (wrok[z]) begin
            mreg[z][dst]  = data;
            mpend[z][dst] = 1'b0;
         end
         if (acc[z]) mpend[z][iss_dst] = 1'b1;
         if (sb_clr)
            for (int a = 0; a < 16; a++) mpend[z][a] = 1'b0;
         mcnt[z] = 0;
         for (int a = 0; a < 16; a++) mcnt[z] += int'(mpend[z][a]);
         mdbg[z] = dn[z];
         chk($sformatf("pend_cnt%0d", z), 32'(pend_cnt[z]), 32'(mcnt[z]));
         chk($sformatf("dbg%0d", z), 32'(dbg_data[z]), 32'(mdbg[z]));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {we, iss_vld, sb_clr} = '0;
      {dst, src0, src1, iss_dst, dbg_sel} = '0;
      data = '0;
      m_reset();
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset image and idle scoreboard
      src0 = 4'd0; src1 = 4'd1; iss_vld = 1'b1; iss_dst = 4'd2;
      #1;
      chk("rst_outa", 32'(outa[0]), 32'h800320);
      chk("rst_outb", 32'(outb[0]), 32'h430002);
      chk("rst_cnt", 32'(pend_cnt[0]), 32'd0);
      chk("rst_stall", 32'(stall[0]), 32'd0);
      cyc();

      // RAW stall then release after writeback
      iss_dst = 4'd5;
      cyc();
      src0 = 4'd5; iss_dst = 4'd9;
      #1;
      chk("raw_stall", 32'(stall[0]), 32'd1);
      chk("raw_busy0", 32'(busy0[0]), 32'd1);
      cyc();
      iss_vld = 1'b0; we = 1'b1; dst = 4'd5; data = 24'h00ABCD;
      cyc();
      we = 1'b0; iss_vld = 1'b1; iss_dst = 4'd9;
      #1;
      chk("rel_stall", 32'(stall[0]), 32'd0);
      chk("rel_outa", 32'(outa[0]), 32'h00ABCD);
      cyc();

      // issue and writeback to the same address: issue wins
      src0 = 4'd0; src1 = 4'd1; iss_dst = 4'd7;
      we = 1'b1; dst = 4'd7; data = 24'h777777;
      cyc();
      we = 1'b0; iss_vld = 1'b0; src0 = 4'd7;
      #1;
      chk("same_busy", 32'(busy0[0]), 32'd1);
      chk("same_data", 32'(outa[0]), 32'h777777);
      cyc();
      src0 = 4'd0; sb_clr = 1'b1; iss_vld = 1'b1; iss_dst = 4'd8;
      cyc();
      chk("clr_cnt", 32'(pend_cnt[0]), 32'd0);
      sb_clr = 1'b0; iss_vld = 1'b0; src0 = 4'd7;
      #1;
      chk("clr_data", 32'(outa[0]), 32'h777777);
      chk("clr_busy", 32'(busy0[0]), 32'd0);
      cyc();

      // hardwired zero register
      we = 1'b1; dst = 4'd0; data = 24'hFFFFFF;
      cyc();
      we = 1'b0; src0 = 4'd0; iss_vld = 1'b1; iss_dst = 4'd0;
      #1;
      chk("z_outa", 32'(outa[1]), 32'd0);
      chk("z_stall", 32'(stall[1]), 32'd0);
      cyc();
      chk("z_cnt", 32'(pend_cnt[1]), 32'd0);

      // fill the scoreboard, then reset mid-cycle
      iss_vld = 1'b0; sb_clr = 1'b1;
      cyc();
      sb_clr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         iss_vld = 1'b1; iss_dst = 4'(i); src0 = 4'(i); src1 = 4'(i);
         cyc();
      end
      iss_vld = 1'b0;
      chk("full_cnt", 32'(pend_cnt[0]), 32'd16);
      chk("full_cntz", 32'(pend_cnt[1]), 32'd15);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("arst_cnt", 32'(pend_cnt[0]), 32'd0);
      chk("arst_cntz", 32'(pend_cnt[1]), 32'd0);
      chk("arst_dbg", 32'(dbg_data[0]), 32'd0);
      for (int a = 0; a < 16; a++) begin
         src0 = 4'(a);
         #1;
         chk($sformatf("arst_reg%0d", a), 32'(outa[0]), 32'(rv_slice(0, a)));
         chk($sformatf("arst_regz%0d", a), 32'(outa[1]), 32'(rv_slice(1, a)));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // writeback to a pending source in the same cycle
      src0 = 4'd0; src1 = 4'd0; iss_vld = 1'b1; iss_dst = 4'd3;
      cyc();
      iss_vld = 1'b0; we = 1'b1; dst = 4'd3; data = 24'h123456; src1 = 4'd3;
      #1;
      chk("byp_outb", 32'(outb[0]), BYP ? 32'h123456 : 32'(rv_slice(0, 3)));
      chk("byp_busy1", 32'(busy1[0]), BYP ? 32'd0 : 32'd1);
      cyc();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         we      = ($urandom_range(0, 99) < 45);
         dst     = 4'($urandom);
         data    = 24'($urandom);
         src0    = 4'($urandom);
         src1    = 4'($urandom);
         iss_vld = ($urandom_range(0, 99) < 70);
         iss_dst = 4'($urandom);
         sb_clr  = ($urandom_range(0, 39) == 0);
         dbg_sel = 4'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
